n64_frame_receiver: RTL and testbench

Parametrised successor to the N64 serial-to-parallel stage. Decodes the raw N64 one-wire controller response directly from the line, oversampled on the system clock, with no external bit clock or latch strobe. Delivers a FRAME_BITS-wide word with a valid pulse and error flagging. Its output feeds the button converter; it replaces the enable_latch/clock-driven capture.

---
 rtl/n64_frame_receiver.sv | 136 +++++++++++++
 tb/tb_n64_frame_receiver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/n64_frame_receiver.sv
// rtl/n64_frame_receiver.sv - oversampled N64 one-wire response frame decoder
module n64_frame_receiver #(
    parameter int CLKS_PER_US = 12,
    parameter int FRAME_BITS  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_US  = 6
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              line_in,
    input  logic                              enable,
    output logic [FRAME_BITS-1:0]             frame_data,
    output logic                              frame_valid,
    output logic                              frame_error,
    output logic                              busy,
    output logic [$clog2(FRAME_BITS+2)-1:0]   bit_count
);

    localparam int SAMPLE  = 2 * CLKS_PER_US;
    localparam int TIMEOUT = TIMEOUT_US * CLKS_PER_US;
    localparam int TW      = $clog2(TIMEOUT + 1);
    localparam int CW      = $clog2(FRAME_BITS + 2);

    localparam logic [TW-1:0] SAMPLE_LAST  = TW'(SAMPLE - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] BIT_MAX      = CW'(FRAME_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_WAIT_HIGH,
        S_HIGH,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    line_s;
    logic                    line_prev;
    logic                    fall;
    logic [TW-1:0]           timer;
    logic [FRAME_BITS-1:0]   shift_reg;

    assign line_s = sync_q[SYNC_STAGES-1];
    assign fall   = line_prev & ~line_s;
    assign busy   = (state != S_IDLE);

    // Bring the asynchronous line into the clock domain; idle level is high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '1;
            line_prev <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], line_in};
            line_prev <= line_s;
        end
    end

    // Bit-cell decoder: time each low phase, sample at mid-cell, police gaps.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            timer       <= '0;
            bit_count   <= '0;
            shift_reg   <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            if (!enable) begin
                state     <= S_IDLE;
                timer     <= '0;
                bit_count <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        timer     <= '0;
                        bit_count <= '0;
                        if (fall) begin
                            state <= S_LOW;
                        end
                    end
                    S_LOW: begin
                        if (timer == SAMPLE_LAST) begin
                            if (bit_count < BIT_MAX) begin
                                shift_reg <= (shift_reg << 1) | FRAME_BITS'(line_s);
                                bit_count <= bit_count + 1'b1;
                                timer     <= timer + 1'b1;
                                state     <= S_WAIT_HIGH;
                            end else if (line_s) begin
                                // Stop bit read as 1: publish the word during DONE.
                                frame_data  <= shift_reg;
                                frame_valid <= 1'b1;
                                state       <= S_DONE;
                            end else begin
                                frame_error <= 1'b1;
                                state       <= S_ERROR;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_WAIT_HIGH: begin
                        if (line_s) begin
                            timer <= '0;
                            state <= S_HIGH;
                        end else if (timer == TIMEOUT_LAST) begin
                            frame_error <= 1'b1;
                            state       <= S_ERROR;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_HIGH: begin
                        if (fall) begin
                            timer <= '0;
                            state <= S_LOW;
                        end else if (timer == TIMEOUT_LAST) begin
                            frame_error <= 1'b1;
                            state       <= S_ERROR;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    S_ERROR: state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_n64_frame_receiver.sv
// tb/tb_n64_frame_receiver.sv - self-checking bench for n64_frame_receiver
module tb_n64_frame_receiver;

    localparam int CPU     = 12;
    localparam int FB      = 32;
    localparam int SYNC    = 2;
    localparam int TO_US   = 6;
    localparam int SAMPLE  = 2 * CPU;
    localparam int LATENCY = SAMPLE + SYNC + 1;
    localparam int ERR_MAX = TO_US * CPU + SYNC + 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          line_in;
    logic          enable;
    logic [FB-1:0] frame_data;
    logic          frame_valid;
    logic          frame_error;
    logic          busy;
    logic [5:0]    bit_count;

    n64_frame_receiver #(
        .CLKS_PER_US(CPU),
        .FRAME_BITS (FB),
        .SYNC_STAGES(SYNC),
        .TIMEOUT_US (TO_US)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .line_in    (line_in),
        .enable     (enable),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
        .frame_error(frame_error),
        .busy       (busy),
        .bit_count  (bit_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    int n_valid = 0;
    int n_error = 0;
    int n_both = 0;
    int valid_cyc = 0;
    int err_cyc = 0;
    int fall_cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    logic [FB-1:0] exp_data;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (frame_valid) begin
            n_valid++;
            valid_cyc = cyc;
        end
        if (frame_error) begin
            n_error++;
            err_cyc = cyc;
        end
        if (frame_valid && frame_error) n_both++;
    end

    typedef struct {
        logic [31:0] word;
        int          nbits;
        int          gap_us;
        logic        exp_valid;
        logic        exp_error;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        line_in  = 1'b0;
        fall_cyc = cyc;
        wait_cycles(b ? CPU : 3 * CPU);
        line_in = 1'b1;
        wait_cycles(b ? 3 * CPU : CPU);
    endtask

    task automatic send_frame(input logic [31:0] word, input int nbits);
        logic [31:0] w;
        w = word;
        for (int i = 0; i < nbits; i++) send_bit(w[31-i]);
        if (nbits == FB) send_bit(1'b1);
        else wait_cycles(10 * CPU);
    endtask

    task automatic run_frame(input string name, input logic [31:0] word, input int nbits,
                             input int gap_us, input logic ev, input logic ee,
                             input logic [31:0] ed);
        int v0;
        int e0;
        v0 = n_valid;
        e0 = n_error;
        send_frame(word, nbits);
        wait_cycles(gap_us * CPU);
        check({name, " valid_pulses"}, 64'(n_valid - v0), ev ? 64'd1 : 64'd0);
        check({name, " error_pulses"}, 64'(n_error - e0), ee ? 64'd1 : 64'd0);
        check({name, " frame_data"}, 64'(frame_data), 64'(ed));
        check({name, " busy_after"}, 64'(busy), 64'd0);
        if (ev) check({name, " latency"}, 64'(valid_cyc - fall_cyc), 64'(LATENCY));
    endtask

    initial begin
        int v0;
        int e0;
        int fc;
        logic [31:0] w;
        int nb;
        int gap;

        vecs[0] = '{32'h8000_0000, 32, 0, 1'b1, 1'b0, 32'h8000_0000};
        vecs[1] = '{32'h1234_A5F0, 32, 0, 1'b1, 1'b0, 32'h1234_A5F0};
        vecs[2] = '{32'hFFFF_FFFF, 32, 1, 1'b1, 1'b0, 32'hFFFF_FFFF};
        vecs[3] = '{32'h0000_0001, 32, 1, 1'b1, 1'b0, 32'h0000_0001};
        vecs[4] = '{32'hC0FF_EE00, 20, 0, 1'b0, 1'b1, 32'h0000_0001};
        vecs[5] = '{32'hDEAD_BEEF, 32, 2, 1'b1, 1'b0, 32'hDEAD_BEEF};

        reset_n = 1'b0;
        line_in = 1'b1;
        enable  = 1'b1;
        wait_cycles(3);
        check("reset frame_data", 64'(frame_data), 64'd0);
        check("reset frame_valid", 64'(frame_valid), 64'd0);
        check("reset frame_error", 64'(frame_error), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset bit_count", 64'(bit_count), 64'd0);
        reset_n = 1'b1;
        wait_cycles(4);

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].word, vecs[i].nbits, vecs[i].gap_us,
                      vecs[i].exp_valid, vecs[i].exp_error, vecs[i].exp_data);
        end
        exp_data = 32'hDEAD_BEEF;

        // Line held low for 8 us after a falling edge.
        v0 = n_valid;
        e0 = n_error;
        line_in = 1'b0;
        fc = cyc;
        wait_cycles(8 * CPU);
        line_in = 1'b1;
        wait_cycles(2 * CPU);
        check("stuck_low error_pulses", 64'(n_error - e0), 64'd1);
        check("stuck_low valid_pulses", 64'(n_valid - v0), 64'd0);
        check("stuck_low error_in_time", 64'((err_cyc - fc) <= ERR_MAX && (err_cyc - fc) > 0), 64'd1);
        check("stuck_low frame_data", 64'(frame_data), 64'(exp_data));

        // Enable dropped at the start of bit 10.
        v0 = n_valid;
        e0 = n_error;
        w = 32'h5555_5555;
        for (int i = 0; i < 10; i++) send_bit(w[31-i]);
        check("abort busy_before", 64'(busy), 64'd1);
        line_in = 1'b0;
        enable  = 1'b0;
        wait_cycles(1);
        check("abort busy_next_cycle", 64'(busy), 64'd0);
        wait_cycles(3 * CPU);
        line_in = 1'b1;
        wait_cycles(5 * CPU);
        enable = 1'b1;
        wait_cycles(CPU);
        check("abort valid_pulses", 64'(n_valid - v0), 64'd0);
        check("abort error_pulses", 64'(n_error - e0), 64'd0);
        check("abort frame_data", 64'(frame_data), 64'(exp_data));
        check("abort bit_count", 64'(bit_count), 64'd0);

        // Asynchronous reset in the middle of a frame.
        w = 32'hA5A5_0000;
        for (int i = 0; i < 5; i++) send_bit(w[31-i]);
        line_in = 1'b0;
        wait_cycles(5);
        reset_n = 1'b0;
        #1;
        check("midreset frame_data", 64'(frame_data), 64'd0);
        check("midreset frame_valid", 64'(frame_valid), 64'd0);
        check("midreset frame_error", 64'(frame_error), 64'd0);
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset bit_count", 64'(bit_count), 64'd0);
        wait_cycles(3);
        line_in = 1'b1;
        reset_n = 1'b1;
        wait_cycles(5);
        exp_data = 32'h0BAD_F00D;
        run_frame("after_reset", 32'h0BAD_F00D, 32, 0, 1'b1, 1'b0, exp_data);

        // Random frames against the reference model.
        for (int k = 0; k < 8; k++) begin
            w   = $urandom;
            nb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : FB;
            gap = $urandom_range(0, 3);
            if (nb == FB) exp_data = w;
            run_frame($sformatf("rand%0d", k), w, nb, gap, nb == FB, nb != FB, exp_data);
        end

        check("valid_error_exclusive", 64'(n_both), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
